// File: rtl/ysyx_22040759_alu_issue_pkg.sv
// Shared ALU definitions: alu_sel function codes, RV64I opcode/funct
// constants, the W-mode select bit and the issue skid buffer state type.
// The EX-stage ALU imports the same package so both sides agree on codes.
package ysyx_22040759_alu_issue_pkg;

  localparam int ALU_XLEN     = 64;
  localparam int ALU_SEL_W    = 5;
  localparam int ALU_SEL_WBIT = 4;

  localparam logic [4:0] ALU_W_MASK = 5'b1 << ALU_SEL_WBIT;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SUB  = 5'b00001,
    ALU_SLL  = 5'b00010,
    ALU_SLT  = 5'b00011,
    ALU_SLTU = 5'b00100,
    ALU_XOR  = 5'b00101,
    ALU_SRL  = 5'b00110,
    ALU_SRA  = 5'b00111,
    ALU_OR   = 5'b01000,
    ALU_AND  = 5'b01001,
    ALU_ADDW = 5'b10000,
    ALU_SUBW = 5'b10001,
    ALU_SLLW = 5'b10010,
    ALU_SRLW = 5'b10110,
    ALU_SRAW = 5'b10111
  } aluSel_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skidState_e;

  // Maps funct3 to the base ALU function; alt selects sub / sra.
  function automatic aluSel_e opSel(input logic [2:0] f3, input logic alt);
    aluSel_e sel;
    case (f3)
      F3_ADDSUB: sel = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:    sel = ALU_SLL;
      F3_SLT:    sel = ALU_SLT;
      F3_SLTU:   sel = ALU_SLTU;
      F3_XOR:    sel = ALU_XOR;
      F3_SR:     sel = alt ? ALU_SRA : ALU_SRL;
      F3_OR:     sel = ALU_OR;
      default:   sel = ALU_AND;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ysyx_22040759_alu_decode.sv
// Combinational RV64I integer-op decoder feeding the ALU issue buffer.
// Produces ALU operands, function select and writeback tags; anything it
// does not recognise is marked illegal with zero operands and an add select.
module ysyx_22040759_alu_decode
  import ysyx_22040759_alu_issue_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic [31:0]      i_inst,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_rs2,
  output logic [XLEN-1:0]  o_a,
  output logic [XLEN-1:0]  o_b,
  output logic [SEL_W-1:0] o_sel,
  output logic [4:0]       o_rd,
  output logic             o_wen,
  output logic             o_illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [5:0]      w_f6;
  logic [XLEN-1:0] w_immI;
  logic [XLEN-1:0] w_immU;
  logic [XLEN-1:0] w_shamt;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [4:0]      w_sel;
  logic            w_legal;
  logic            w_unusedRs1Idx;

  assign w_opcode = i_inst[6:0];
  assign w_f3     = i_inst[14:12];
  assign w_f7     = i_inst[31:25];
  assign w_f6     = i_inst[31:26];
  assign w_immI   = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
  assign w_immU   = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
  assign w_shamt  = {{(XLEN-6){1'b0}}, i_inst[25:20]};

  // The register index field is consumed by register read upstream.
  assign w_unusedRs1Idx = ^i_inst[19:15];

  // Opcode/funct decode; illegal encodings fall through with defaults.
  always_comb begin
    w_legal = 1'b0;
    w_sel   = ALU_ADD;
    w_a     = '0;
    w_b     = '0;
    case (w_opcode)
      OPC_OP: begin
        if (w_f7 == F7_BASE ||
            (w_f7 == F7_ALT && (w_f3 == F3_ADDSUB || w_f3 == F3_SR))) begin
          w_legal = 1'b1;
          w_a     = i_rs1;
          w_b     = i_rs2;
          w_sel   = opSel(w_f3, w_f7 == F7_ALT);
        end
      end
      OPC_OP_IMM: begin
        if (w_f3 == F3_SLL) begin
          if (w_f6 == F6_BASE) begin
            w_legal = 1'b1;
            w_a     = i_rs1;
            w_b     = w_shamt;
            w_sel   = ALU_SLL;
          end
        end else if (w_f3 == F3_SR) begin
          if (w_f6 == F6_BASE || w_f6 == F6_ALT) begin
            w_legal = 1'b1;
            w_a     = i_rs1;
            w_b     = w_shamt;
            w_sel   = opSel(F3_SR, w_f6 == F6_ALT);
          end
        end else begin
          w_legal = 1'b1;
          w_a     = i_rs1;
          w_b     = w_immI;
          w_sel   = opSel(w_f3, 1'b0);
        end
      end
      OPC_OP_32: begin
        if (((w_f3 == F3_ADDSUB || w_f3 == F3_SR) &&
             (w_f7 == F7_BASE || w_f7 == F7_ALT)) ||
            (w_f3 == F3_SLL && w_f7 == F7_BASE)) begin
          w_legal = 1'b1;
          w_a     = i_rs1;
          w_b     = i_rs2;
          w_sel   = opSel(w_f3, w_f7 == F7_ALT) | ALU_W_MASK;
        end
      end
      OPC_OP_IMM_32: begin
        if (w_f3 == F3_ADDSUB) begin
          w_legal = 1'b1;
          w_a     = i_rs1;
          w_b     = w_immI;
          w_sel   = ALU_ADDW;
        end else if ((w_f3 == F3_SLL && w_f7 == F7_BASE) ||
                     (w_f3 == F3_SR && (w_f7 == F7_BASE || w_f7 == F7_ALT))) begin
          w_legal = 1'b1;
          w_a     = i_rs1;
          w_b     = w_shamt;
          w_sel   = opSel(w_f3, w_f7 == F7_ALT) | ALU_W_MASK;
        end
      end
      OPC_LUI: begin
        w_legal = 1'b1;
        w_b     = w_immU;
      end
      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_a     = i_pc;
        w_b     = w_immU;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  assign o_a       = w_a;
  assign o_b       = w_b;
  assign o_sel     = SEL_W'(w_sel);
  assign o_rd      = i_inst[11:7];
  assign o_wen     = w_legal & (i_inst[11:7] != 5'd0);
  assign o_illegal = ~w_legal;

endmodule

// File: rtl/ysyx_22040759_alu_issue.sv
// ALU issue stage: decodes integer ops from register read and hands them to
// EX through a 2-entry skid buffer, so in_ready comes straight from a flop
// and a full-rate stream still moves one op per cycle.
// Optional build macro ALU_ISSUE_STAT_EN adds handshake/illegal counters.
module ysyx_22040759_alu_issue
  import ysyx_22040759_alu_issue_pkg::*;
#(
  parameter int XLEN  = ALU_XLEN,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [SEL_W-1:0] alu_sel,
  output logic [4:0]       out_rd,
  output logic             out_rd_wen,
  output logic             out_illegal,
`ifdef ALU_ISSUE_STAT_EN
  output logic [63:0]      stat_issued,
  output logic [31:0]      stat_illegal,
`endif
  output logic [XLEN-1:0]  out_pc
);

  typedef struct packed {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  pc;
    logic [SEL_W-1:0] sel;
    logic [4:0]       rd;
    logic             wen;
    logic             illegal;
  } issueOp_t;

  issueOp_t   w_dec;
  issueOp_t   r_main;
  issueOp_t   r_skid;
  skidState_e r_state;
  logic       r_inReady;
  logic       r_outValid;
  logic       w_accept;

  ysyx_22040759_alu_decode #(
    .XLEN  (XLEN),
    .SEL_W (SEL_W)
  ) u_decode (
    .i_inst    (in_inst),
    .i_pc      (in_pc),
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .o_a       (w_dec.a),
    .o_b       (w_dec.b),
    .o_sel     (w_dec.sel),
    .o_rd      (w_dec.rd),
    .o_wen     (w_dec.wen),
    .o_illegal (w_dec.illegal)
  );

  assign w_dec.pc = in_pc;

  // A flush discards whatever upstream offers in the same cycle.
  assign w_accept = in_valid & r_inReady & ~flush;

  // Skid-buffer FSM: main register drives EX, skid catches the op that
  // arrives while EX stalls; ready/valid flags are registered with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main     <= w_dec;
            r_state    <= ST_ONE;
            r_outValid <= 1'b1;
            r_inReady  <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && !out_ready) begin
            r_skid     <= w_dec;
            r_state    <= ST_TWO;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b1;
          end else if (w_accept && out_ready) begin
            r_main     <= w_dec;
            r_state    <= ST_ONE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b1;
          end else if (out_ready) begin
            r_state    <= ST_EMPTY;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            r_main     <= r_skid;
            r_state    <= ST_ONE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_inReady;
  assign out_valid   = r_outValid;
  assign alu_a       = r_main.a;
  assign alu_b       = r_main.b;
  assign alu_sel     = r_main.sel;
  assign out_rd      = r_main.rd;
  assign out_rd_wen  = r_main.wen;
  assign out_illegal = r_main.illegal;
  assign out_pc      = r_main.pc;

`ifdef ALU_ISSUE_STAT_EN
  logic [63:0] r_statIssued;
  logic [31:0] r_statIllegal;

  // Counts ops handed to EX and how many of them were illegal; flush-proof.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statIssued  <= '0;
      r_statIllegal <= '0;
    end else if (r_outValid && out_ready) begin
      r_statIssued <= r_statIssued + 64'd1;
      if (r_main.illegal) begin
        r_statIllegal <= r_statIllegal + 32'd1;
      end
    end
  end

  assign stat_issued  = r_statIssued;
  assign stat_illegal = r_statIllegal;
`endif

endmodule

// File: tb/tb_ysyx_22040759_alu_issue.sv
// Scoreboard bench for the ALU issue buffer: accepted ops are modelled from
// the RV64I rules and queued; a negedge monitor pops and compares on every
// EX handshake and checks valid/ready against the queue occupancy.
module tb_ysyx_22040759_alu_issue;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] pc;
    logic [4:0]  sel;
    logic [4:0]  rd;
    logic        wen;
    logic        ill;
  } expOp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic [63:0] in_rs1 = '0;
  logic [63:0] in_rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [4:0]  alu_sel;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic        out_illegal;
  logic [63:0] out_pc;

  int checks = 0;
  int failures = 0;
  expOp_t sb[$];
  int selBase [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  logic [6:0] opcList [9] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17, 7'h7F, 7'h03, 7'h63};

  ysyx_22040759_alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_sel     (alu_sel),
    .out_rd      (out_rd),
    .out_rd_wen  (out_rd_wen),
    .out_illegal (out_illegal),
    .out_pc      (out_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Reference model: what EX should see for an instruction, from the ISA rules.
  function automatic expOp_t refModel(input logic [31:0] inst, input logic [63:0] pc,
                                      input logic [63:0] rs1, input logic [63:0] rs2);
    expOp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    int sel;
    logic [63:0] a, b;
    longint immI, immU;
    f3 = inst[14:12];
    f7 = inst[31:25];
    immI = longint'($signed(inst[31:20]));
    immU = longint'($signed({inst[31:12], 12'h000}));
    ok = 1'b0;
    sel = 0;
    a = '0;
    b = '0;
    case (inst[6:0])
      7'h33: begin
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        a = rs1; b = rs2;
        sel = selBase[f3] + int'(f7 == 7'h20);
      end
      7'h13: begin
        a = rs1;
        if (f3 == 3'd1) begin
          ok = (inst[31:26] == 6'h00); b = 64'(inst[25:20]); sel = 2;
        end else if (f3 == 3'd5) begin
          ok = (inst[31:26] == 6'h00) || (inst[31:26] == 6'h10);
          b = 64'(inst[25:20]); sel = 6 + int'(inst[30]);
        end else begin
          ok = 1'b1; b = immI; sel = selBase[f3];
        end
      end
      7'h3B: begin
        a = rs1; b = rs2;
        if (f3 == 3'd0 || f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else ok = (f3 == 3'd1) && (f7 == 7'h00);
        sel = 16 + selBase[f3] + int'(f7 == 7'h20);
      end
      7'h1B: begin
        a = rs1;
        if (f3 == 3'd0) begin
          ok = 1'b1; b = immI; sel = 16;
        end else if (f3 == 3'd1) begin
          ok = (f7 == 7'h00); b = 64'(inst[24:20]); sel = 18;
        end else if (f3 == 3'd5) begin
          ok = (f7 == 7'h00) || (f7 == 7'h20); b = 64'(inst[24:20]);
          sel = 22 + int'(f7 == 7'h20);
        end
      end
      7'h37: begin ok = 1'b1; a = '0; b = immU; sel = 0; end
      7'h17: begin ok = 1'b1; a = pc; b = immU; sel = 0; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin a = '0; b = '0; sel = 0; end
    e.a = a;
    e.b = b;
    e.pc = pc;
    e.sel = sel[4:0];
    e.rd = inst[11:7];
    e.wen = ok && (inst[11:7] != 5'd0);
    e.ill = !ok;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic compareOp(input expOp_t e);
    checks++;
    if (alu_a !== e.a || alu_b !== e.b || alu_sel !== e.sel || out_rd !== e.rd ||
        out_rd_wen !== e.wen || out_illegal !== e.ill || out_pc !== e.pc) begin
      failures++;
      $display("[TB] FAIL op_compare: actual a=%h b=%h sel=%b rd=%0d wen=%b ill=%b pc=%h required a=%h b=%h sel=%b rd=%0d wen=%b ill=%b pc=%h",
               alu_a, alu_b, alu_sel, out_rd, out_rd_wen, out_illegal, out_pc,
               e.a, e.b, e.sel, e.rd, e.wen, e.ill, e.pc);
    end
  endtask

  // Monitor: compare presented op, retire on handshake, then record accepts.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      checkOutput("out_valid_occupancy", 64'(out_valid), 64'(sb.size() > 0));
      checkOutput("in_ready_occupancy", 64'(in_ready), 64'(sb.size() < 2));
      if (out_valid && sb.size() > 0) begin
        compareOp(sb[0]);
        if (out_ready) void'(sb.pop_front());
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(refModel(in_inst, in_pc, in_rs1, in_rs2));
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                               input logic [63:0] rs1, input logic [63:0] rs2,
                               input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v;
    in_inst = inst;
    in_pc = pc;
    in_rs1 = rs1;
    in_rs2 = rs2;
    out_ready = rdy;
    flush = fl;
  endtask

  function automatic logic [31:0] genInst();
    logic [31:0] w;
    w = $urandom;
    w[6:0] = opcList[$urandom_range(0, 8)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_alu_a", alu_a, 64'd0);
    checkOutput("reset_alu_b", alu_b, 64'd0);
    checkOutput("reset_alu_sel", 64'(alu_sel), 64'd0);
    checkOutput("reset_out_pc", out_pc, 64'd0);
    checkOutput("reset_rd_wen", 64'(out_rd_wen), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // add x3,x1,x2
    applyStimulus(1'b1, 32'h002081B3, 64'h1000, 64'd5, 64'd7, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("add_valid", 64'(out_valid), 64'd1);
    checkOutput("add_a", alu_a, 64'd5);
    checkOutput("add_b", alu_b, 64'd7);
    checkOutput("add_sel", 64'(alu_sel), 64'd0);
    checkOutput("add_rd", 64'(out_rd), 64'd3);
    checkOutput("add_wen", 64'(out_rd_wen), 64'd1);

    // addi x1,x0,-1
    applyStimulus(1'b1, 32'hFFF00093, 64'h1004, 64'd0, 64'd9, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("addi_b", alu_b, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("addi_sel", 64'(alu_sel), 64'd0);
    checkOutput("addi_wen", 64'(out_rd_wen), 64'd1);

    // sraiw x5,x6,3
    applyStimulus(1'b1, 32'h4033529B, 64'h1008, 64'h8000_0000, 64'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("sraiw_a", alu_a, 64'h8000_0000);
    checkOutput("sraiw_b", alu_b, 64'd3);
    checkOutput("sraiw_sel", 64'(alu_sel), 64'b10111);

    // lui x1,0x80000
    applyStimulus(1'b1, 32'h800000B7, 64'h100C, 64'h1234, 64'h5678, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("lui_a", alu_a, 64'd0);
    checkOutput("lui_b", alu_b, 64'hFFFF_FFFF_8000_0000);

    // undecodable opcode
    applyStimulus(1'b1, 32'h0000007F, 64'h1010, 64'h1234, 64'h5678, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("illegal_flag", 64'(out_illegal), 64'd1);
    checkOutput("illegal_wen", 64'(out_rd_wen), 64'd0);
    checkOutput("illegal_a", alu_a, 64'd0);

    // Backpressure: A, B fill the buffer, C waits upstream, then all drain in order.
    applyStimulus(1'b1, 32'h002081B3, 64'h2000, 64'd1, 64'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40208233, 64'h2004, 64'd3, 64'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0020C2B3, 64'h2008, 64'd5, 64'd6, 1'b0, 1'b0);
    checkOutput("two_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h0020C2B3, 64'h2008, 64'd5, 64'd6, 1'b0, 1'b0);
    checkOutput("two_hold_pc", out_pc, 64'h2000);
    applyStimulus(1'b1, 32'h0020C2B3, 64'h2008, 64'd5, 64'd6, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0020C2B3, 64'h2008, 64'd5, 64'd6, 1'b1, 1'b0);
    checkOutput("drain_b_pc", out_pc, 64'h2004);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("drain_c_pc", out_pc, 64'h2008);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("drain_empty_valid", 64'(out_valid), 64'd0);

    // Flush with the buffer full and a new op offered in the same cycle.
    applyStimulus(1'b1, 32'h002081B3, 64'h3000, 64'd1, 64'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h002081B3, 64'h3004, 64'd3, 64'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h002081B3, 64'h3008, 64'd5, 64'd6, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);

    // Asynchronous reset while the buffer holds two ops.
    applyStimulus(1'b1, 32'h002081B3, 64'h4000, 64'd1, 64'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h002081B3, 64'h4004, 64'd3, 64'd4, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("async_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("async_rst_alu_a", alu_a, 64'd0);
    checkOutput("async_rst_out_pc", out_pc, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    checkOutput("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, genInst(), {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom},
                    $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0);
    end
    @(negedge clk);
    #1;
    checkOutput("final_queue_empty", 64'(sb.size()), 64'd0);
    checkOutput("final_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22040759_alu_issue.md
Name: ysyx_22040759_alu_issue

Overview:
- Producer side of the integer ALU interface: decodes RV64I integer ops and drives alu_a / alu_b / alu_sel plus writeback tags into the EX stage.
- Sits between register read (ID) and EX; decouples them with a 2-entry skid buffer (valid/ready both sides), so in_ready is a register output and throughput is 1 op/cycle.
- Flags undecodable instructions instead of dropping them.

Parameters:
- XLEN, 64, operand / pc width
- SEL_W, 5, alu_sel width; bit 4 = 32-bit (W) mode

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all buffered ops (branch redirect)
- in_valid  in  1  upstream op valid
- in_ready  out  1  buffer can accept (registered)
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction pc
- in_rs1  in  XLEN  rs1 value
- in_rs2  in  XLEN  rs2 value
- out_valid  out  1  op presented to EX
- out_ready  in  1  EX accepts
- alu_a  out  XLEN  ALU operand A
- alu_b  out  XLEN  ALU operand B
- alu_sel  out  SEL_W  ALU function
- out_rd  out  5  destination register
- out_rd_wen  out  1  writeback enable
- out_illegal  out  1  undecodable instruction
- out_pc  out  XLEN  pc of presented op

Behaviour:
- Reset (async, while rst=1): state EMPTY; in_ready=1, out_valid=0, all data outputs 0.
- Decode is combinational on input; result is captured at the accepting edge (in_valid & in_ready). out_valid rises the next cycle (latency 1).
- alu_sel encoding (shared package): add 00000, sub 00001, sll 00010, slt 00011, sltu 00100, xor 00101, srl 00110, sra 00111, or 01000, and 01001; W ops set bit4: addw 10000, subw 10001, sllw 10010, srlw 10110, sraw 10111.
- OP (0110011): a=rs1, b=rs2; funct7 must be 0000000, or 0100000 for add→sub / srl→sra only.
- OP-IMM (0010011): a=rs1, b=sext(inst[31:20]); shifts use funct6=inst[31:26] (000000, or 010000 for srai), b={58'b0,inst[25:20]}.
- OP-32 (0111011): add/sub/sll/srl/sra only, W codes.
- OP-IMM-32 (0011011): addiw, slliw/srliw/sraiw; shift needs inst[25]=0.
- LUI (0110111): a=0, b=sext({inst[31:12],12'b0}), add. AUIPC (0010111): a=pc, same b, add.
- Any other opcode/funct combination: out_illegal=1, alu_sel=add, a=b=0, rd_wen=0; still flows through the buffer in order.
- out_rd=inst[11:7]; out_rd_wen=legal & rd!=0.
- FSM: EMPTY (in_ready=1, out_valid=0); ONE (main full, in_ready=1, out_valid=1); TWO (main+skid full, in_ready=0, out_valid=1).
  - EMPTY: accept→ONE.
  - ONE: accept & !out_ready→TWO (new op into skid); accept & out_ready→ONE (main reloaded); !accept & out_ready→EMPTY.
  - TWO: out_ready→ONE (skid moves to main); else hold.
- Output is stable while out_valid & !out_ready; strict FIFO order.
- flush: next state EMPTY, any same-cycle input is dropped, out_valid=0 next cycle; flush has priority over every transition.

Optional Feature:
- ALU_ISSUE_STAT_EN: adds outputs stat_issued (64) and stat_illegal (32), counting output handshakes and illegal ones handed off. Both reset to 0, wrap at max, and are not cleared by flush. Without the macro the ports and counters do not exist.

Decomposition:
- Shared define/package: alu_sel codes, opcode constants, funct3/funct7 constants, and the W-mode bit index. The existing ALU uses the same file.
- One sub-module: ysyx_22040759_alu_decode, purely combinational (inst, pc, rs1, rs2 → a, b, sel, rd, wen, illegal). The parent holds the skid FSM.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 → next cycle a=5, b=7, sel=00000, rd=3, wen=1.
- addi x1,x0,-1 (0xFFF00093) → b=0xFFFFFFFFFFFFFFFF, sel=add, wen=1. sraiw x5,x6,3 (0x4033529B), rs1=0x80000000 → b=3, sel=10111.
- LUI x1,0x80000 (0x800000B7) → a=0, b=0xFFFFFFFF80000000. Opcode 0x0000007F → illegal=1, wen=0.
- out_ready=0, send ops A then B → in_ready=0 after B; C held upstream. Release out_ready → A, B, C emerge in order, 1 per cycle.
- Buffer in TWO, assert flush with in_valid=1 → out_valid=0 and in_ready=1 next cycle; the flushed input never appears.
- Assert rst mid-stream in TWO → outputs clear immediately (async), EMPTY after release.
